// File: rtl/pe_mem_arbiter_if.sv
// Shared memory port bundle: PE strobes, CPU valid/ready bus,
// memory macro signals and sticky status flags.
interface pe_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              pe_req_1;
  logic [ADDR_W-1:0] pe_addr_1;
  logic              pe_req_2;
  logic [ADDR_W-1:0] pe_addr_2;
  logic              pe_rvalid_1;
  logic [DATA_W-1:0] pe_rdata_1;
  logic              pe_rvalid_2;
  logic [DATA_W-1:0] pe_rdata_2;
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              pe_conflict;
  logic              pe_overrun;
  logic              cpu_starve;

  modport master (
    output pe_req_1, pe_addr_1,
    output pe_req_2, pe_addr_2,
    output cpu_valid, cpu_we,
    output cpu_addr, cpu_wdata,
    output mem_rdata,
    input  pe_rvalid_1, pe_rdata_1,
    input  pe_rvalid_2, pe_rdata_2,
    input  cpu_ready, cpu_rvalid,
    input  cpu_rdata,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    input  pe_conflict, pe_overrun,
    input  cpu_starve
  );

  modport slave (
    input  pe_req_1, pe_addr_1,
    input  pe_req_2, pe_addr_2,
    input  cpu_valid, cpu_we,
    input  cpu_addr, cpu_wdata,
    input  mem_rdata,
    output pe_rvalid_1, pe_rdata_1,
    output pe_rvalid_2, pe_rdata_2,
    output cpu_ready, cpu_rvalid,
    output cpu_rdata,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    output pe_conflict, pe_overrun,
    output cpu_starve
  );
endinterface

// File: rtl/pe_mem_arbiter.sv
// Single-port VRAM/palette arbiter: two PE read slots with a one-deep
// skid for slot 2, CPU takes leftover cycles, fixed 2-cycle read latency.
module pe_mem_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic clock,
  input logic reset,
  pe_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_PE1,
    TAG_PE2,
    TAG_CPU
  } tag_e;

  logic              r_skid_v;
  logic [ADDR_W-1:0] r_skid_addr;
  tag_e              r_tag_s1;
  tag_e              r_tag_s2;
  logic [DATA_W-1:0] r_rdata_1;
  logic [DATA_W-1:0] r_rdata_2;
  logic [DATA_W-1:0] r_rdata_c;
  logic              r_conflict;
  logic              r_overrun;
  logic              r_starve;
  logic [CW-1:0]     r_wait;

  logic              w_ready;
  logic              w_g_pe1;
  logic              w_g_skid;
  logic              w_g_pe2;
  logic              w_g_cpu;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  tag_e              w_tag;
  logic [CW-1:0]     w_wait_nxt;

  assign w_ready  = !reset && !bus.pe_req_1
                 && !r_skid_v && !bus.pe_req_2;
  assign w_g_pe1  = !reset && bus.pe_req_1;
  assign w_g_skid = !reset && !bus.pe_req_1
                 && r_skid_v;
  assign w_g_pe2  = !reset && !bus.pe_req_1
                 && !r_skid_v && bus.pe_req_2;
  assign w_g_cpu  = w_ready && bus.cpu_valid;

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    w_tag   = TAG_NONE;
    if (w_g_pe1) begin
      w_addr = bus.pe_addr_1;
      w_tag  = TAG_PE1;
    end else if (w_g_skid) begin
      w_addr = r_skid_addr;
      w_tag  = TAG_PE2;
    end else if (w_g_pe2) begin
      w_addr = bus.pe_addr_2;
      w_tag  = TAG_PE2;
    end else if (w_g_cpu) begin
      w_addr = bus.cpu_addr;
      w_we   = bus.cpu_we;
      if (bus.cpu_we) w_wdata = bus.cpu_wdata;
      else            w_tag   = TAG_CPU;
    end
  end

  // Saturating wait counter; any non-blocked cycle restarts it
  always_comb begin
    w_wait_nxt = '0;
    if (bus.cpu_valid && !w_ready) begin
      w_wait_nxt = r_wait;
      if (r_wait != CW'(STARVE_LIMIT))
        w_wait_nxt = r_wait + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_skid_v    <= 1'b0;
      r_skid_addr <= '0;
      r_tag_s1    <= TAG_NONE;
      r_tag_s2    <= TAG_NONE;
      r_rdata_1   <= '0;
      r_rdata_2   <= '0;
      r_rdata_c   <= '0;
      r_conflict  <= 1'b0;
      r_overrun   <= 1'b0;
      r_starve    <= 1'b0;
      r_wait      <= '0;
    end else begin
      r_tag_s1 <= w_tag;
      r_tag_s2 <= r_tag_s1;
      unique case (r_tag_s1)
        TAG_PE1:  r_rdata_1 <= bus.mem_rdata;
        TAG_PE2:  r_rdata_2 <= bus.mem_rdata;
        TAG_CPU:  r_rdata_c <= bus.mem_rdata;
        TAG_NONE: ;
      endcase
      if (bus.pe_req_1 && bus.pe_req_2) begin
        r_conflict <= 1'b1;
        if (r_skid_v) begin
          r_overrun <= 1'b1;
        end else begin
          r_skid_v    <= 1'b1;
          r_skid_addr <= bus.pe_addr_2;
        end
      end else if (!bus.pe_req_1 && r_skid_v) begin
        r_skid_v <= bus.pe_req_2;
        if (bus.pe_req_2)
          r_skid_addr <= bus.pe_addr_2;
      end
      r_wait <= w_wait_nxt;
      if (w_wait_nxt == CW'(STARVE_LIMIT))
        r_starve <= 1'b1;
    end
  end

  assign bus.cpu_ready   = w_ready;
  assign bus.mem_en      = w_g_pe1 | w_g_skid
                         | w_g_pe2 | w_g_cpu;
  assign bus.mem_we      = w_we;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_wdata   = w_wdata;
  assign bus.pe_rvalid_1 = (r_tag_s2 == TAG_PE1);
  assign bus.pe_rvalid_2 = (r_tag_s2 == TAG_PE2);
  assign bus.cpu_rvalid  = (r_tag_s2 == TAG_CPU);
  assign bus.pe_rdata_1  = r_rdata_1;
  assign bus.pe_rdata_2  = r_rdata_2;
  assign bus.cpu_rdata   = r_rdata_c;
  assign bus.pe_conflict = r_conflict;
  assign bus.pe_overrun  = r_overrun;
  assign bus.cpu_starve  = r_starve;
endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Bench for pe_mem_arbiter: memory model, per-cycle reference
// model check, plus directed scenarios with literal expectations.
module tb_pe_mem_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int LIM = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  pe_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", n, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // memory macro
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr] = bus.mem_wdata;
      else
        bus.mem_rdata <= mem.exists(bus.mem_addr) ?
          mem[bus.mem_addr] : dflt(bus.mem_addr);
    end
  end

  // reference model
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq[$];
  logic [AW-1:0] skq[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] m_rd [3];
  int            cyc   = 0;
  int            waitc = 0;
  bit            m_conf, m_ovr, m_starve;

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(negedge clock) begin : model
    bit            p1, p2, cv, we, has_sk, rdy, rv;
    int            g, who;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit            erv [3];
    if (reset) begin
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_ready", bus.cpu_ready, 0);
      chk("rst_rv1", bus.pe_rvalid_1, 0);
      chk("rst_rv2", bus.pe_rvalid_2, 0);
      chk("rst_rvc", bus.cpu_rvalid, 0);
      chk("rst_rd1", bus.pe_rdata_1, 0);
      chk("rst_rd2", bus.pe_rdata_2, 0);
      chk("rst_rdc", bus.cpu_rdata, 0);
      chk("rst_conf", bus.pe_conflict, 0);
      chk("rst_ovr", bus.pe_overrun, 0);
      chk("rst_starve", bus.cpu_starve, 0);
      rq.delete();
      skq.delete();
      waitc    = 0;
      m_conf   = 0;
      m_ovr    = 0;
      m_starve = 0;
      for (int i = 0; i < 3; i++) m_rd[i] = '0;
    end else begin
      p1 = bus.pe_req_1;
      p2 = bus.pe_req_2;
      cv = bus.cpu_valid;
      we = bus.cpu_we;
      has_sk = (skq.size() > 0);
      rdy = !p1 && !has_sk && !p2;
      g = 0; ea = '0; ewd = '0;
      if (p1)          begin g = 1; ea = bus.pe_addr_1; end
      else if (has_sk) begin g = 2; ea = skq[0]; end
      else if (p2)     begin g = 3; ea = bus.pe_addr_2; end
      else if (cv) begin
        g = 4; ea = bus.cpu_addr;
        if (we) ewd = bus.cpu_wdata;
      end
      for (int i = 0; i < 3; i++) erv[i] = 0;
      rv = (rq.size() > 0) && (rq[0].due == cyc);
      if (rv) begin
        erv[rq[0].who]  = 1;
        m_rd[rq[0].who] = rq[0].data;
        void'(rq.pop_front());
      end
      chk("m_mem_en", bus.mem_en, 32'(g != 0));
      chk("m_mem_we", bus.mem_we, 32'(g == 4 && we));
      chk("m_mem_addr", bus.mem_addr, 32'(ea));
      chk("m_mem_wdata", bus.mem_wdata, 32'(ewd));
      chk("m_ready", bus.cpu_ready, 32'(rdy));
      chk("m_rv1", bus.pe_rvalid_1, 32'(erv[0]));
      chk("m_rv2", bus.pe_rvalid_2, 32'(erv[1]));
      chk("m_rvc", bus.cpu_rvalid, 32'(erv[2]));
      chk("m_rd1", bus.pe_rdata_1, 32'(m_rd[0]));
      chk("m_rd2", bus.pe_rdata_2, 32'(m_rd[1]));
      chk("m_rdc", bus.cpu_rdata, 32'(m_rd[2]));
      chk("m_conf", bus.pe_conflict, 32'(m_conf));
      chk("m_ovr", bus.pe_overrun, 32'(m_ovr));
      chk("m_starve", bus.cpu_starve, 32'(m_starve));
      // advance to the next cycle
      who = (g == 1) ? 0 : (g == 4) ? 2 : 1;
      if (g == 4 && we)
        ref_mem[ea] = bus.cpu_wdata;
      else if (g != 0)
        rq.push_back('{due: cyc + 2, who: who,
                       data: ref_rd(ea)});
      if (p1 && p2) begin
        m_conf = 1;
        if (has_sk) m_ovr = 1;
        else        skq.push_back(bus.pe_addr_2);
      end else if (!p1 && has_sk) begin
        void'(skq.pop_front());
        if (p2) skq.push_back(bus.pe_addr_2);
      end
      if (cv && !rdy) begin
        if (waitc < LIM) waitc++;
        if (waitc == LIM) m_starve = 1;
      end else begin
        waitc = 0;
      end
    end
    cyc++;
  end

  task automatic drv(bit p1, logic [AW-1:0] a1,
                     bit p2, logic [AW-1:0] a2,
                     bit cv, bit we,
                     logic [AW-1:0] ca, logic [DW-1:0] wd);
    @(posedge clock);
    #1;
    bus.pe_req_1  = p1;
    bus.pe_addr_1 = a1;
    bus.pe_req_2  = p2;
    bus.pe_addr_2 = a2;
    bus.cpu_valid = cv;
    bus.cpu_we    = we;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = wd;
  endtask

  task automatic idle();
    drv(0, '0, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin : stim
    int n2;
    int nc;
    bus.mem_rdata = '0;
    bus.pe_req_1  = 0;
    bus.pe_addr_1 = '0;
    bus.pe_req_2  = 0;
    bus.pe_addr_2 = '0;
    bus.cpu_valid = 0;
    bus.cpu_we    = 0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // CPU write then read back
    drv(0, '0, 0, '0, 1, 1, 17'h10, 16'h1234);
    @(negedge clock);
    chk("s1_wr_ready", bus.cpu_ready, 1);
    chk("s1_wr_we", bus.mem_we, 1);
    chk("s1_wr_addr", bus.mem_addr, 32'h10);
    drv(0, '0, 0, '0, 1, 0, 17'h10, '0);
    @(negedge clock);
    chk("s1_rd_ready", bus.cpu_ready, 1);
    idle();
    @(negedge clock);
    chk("s1_rv_early", bus.cpu_rvalid, 0);
    idle();
    @(negedge clock);
    chk("s1_rv", bus.cpu_rvalid, 1);
    chk("s1_rdata", bus.cpu_rdata, 16'h1234);

    // PE1 then PE2 with CPU read held
    drv(1, 17'h100, 0, '0, 1, 0, 17'h20, '0);
    @(negedge clock);
    chk("s2_ready_p2", bus.cpu_ready, 0);
    drv(0, '0, 1, 17'h200, 1, 0, 17'h20, '0);
    @(negedge clock);
    chk("s2_ready_p3", bus.cpu_ready, 0);
    drv(0, '0, 0, '0, 1, 0, 17'h20, '0);
    @(negedge clock);
    chk("s2_ready_acc", bus.cpu_ready, 1);
    chk("s2_rv1", bus.pe_rvalid_1, 1);
    chk("s2_rd1", bus.pe_rdata_1, 16'h5B5A);
    idle();
    @(negedge clock);
    chk("s2_rv2", bus.pe_rvalid_2, 1);
    chk("s2_rd2", bus.pe_rdata_2, 16'h585A);
    idle();
    @(negedge clock);
    chk("s2_rvc", bus.cpu_rvalid, 1);
    chk("s2_rdc", bus.cpu_rdata, 16'h5A7A);

    // both PE slots in one cycle
    drv(1, 17'h300, 1, 17'h400, 0, 0, '0, '0);
    @(negedge clock);
    chk("s3_addr_n", bus.mem_addr, 32'h300);
    idle();
    @(negedge clock);
    chk("s3_en_n1", bus.mem_en, 1);
    chk("s3_addr_n1", bus.mem_addr, 32'h400);
    chk("s3_conf", bus.pe_conflict, 1);
    chk("s3_ready_n1", bus.cpu_ready, 0);
    idle();
    @(negedge clock);
    chk("s3_rv1", bus.pe_rvalid_1, 1);
    chk("s3_rd1", bus.pe_rdata_1, 16'h595A);
    chk("s3_rv2_early", bus.pe_rvalid_2, 0);
    idle();
    @(negedge clock);
    chk("s3_rv2", bus.pe_rvalid_2, 1);
    chk("s3_rd2", bus.pe_rdata_2, 16'h5E5A);

    // two back-to-back dual requests: overrun
    n2 = 0;
    drv(1, 17'h500, 1, 17'h600, 0, 0, '0, '0);
    @(negedge clock);
    chk("s4_ovr_0", bus.pe_overrun, 0);
    n2 += int'(bus.pe_rvalid_2);
    drv(1, 17'h510, 1, 17'h610, 0, 0, '0, '0);
    @(negedge clock);
    chk("s4_ovr_1", bus.pe_overrun, 0);
    n2 += int'(bus.pe_rvalid_2);
    idle();
    @(negedge clock);
    chk("s4_ovr_2", bus.pe_overrun, 1);
    chk("s4_skid_addr", bus.mem_addr, 32'h600);
    n2 += int'(bus.pe_rvalid_2);
    for (int i = 0; i < 5; i++) begin
      idle();
      @(negedge clock);
      n2 += int'(bus.pe_rvalid_2);
    end
    chk("s4_rv2_count", 32'(n2), 1);
    chk("s4_rd2", bus.pe_rdata_2, 16'h5C5A);

    // CPU starved by continuous PE1
    chk("s5_starve_pre", bus.cpu_starve, 0);
    for (int i = 0; i < LIM; i++) begin
      drv(1, 17'h700 + 17'(i), 0, '0, 1, 0, 17'h30, '0);
      @(negedge clock);
      chk("s5_blocked", bus.cpu_ready, 0);
      if (i == LIM - 1)
        chk("s5_starve_late", bus.cpu_starve, 0);
    end
    drv(0, '0, 0, '0, 1, 0, 17'h30, '0);
    @(negedge clock);
    chk("s5_starve", bus.cpu_starve, 1);
    chk("s5_accept", bus.cpu_ready, 1);
    idle();
    @(negedge clock);
    chk("s5_starve_held", bus.cpu_starve, 1);
    repeat (3) idle();

    // reset one cycle after a CPU read grant
    drv(0, '0, 0, '0, 1, 0, 17'h10, '0);
    @(negedge clock);
    chk("s6_accept", bus.cpu_ready, 1);
    @(posedge clock);
    #1;
    reset = 1;
    bus.cpu_valid = 0;
    @(negedge clock);
    chk("s6_rst_starve", bus.cpu_starve, 0);
    chk("s6_rst_conf", bus.pe_conflict, 0);
    chk("s6_rst_ready", bus.cpu_ready, 0);
    @(posedge clock);
    #1 reset = 0;
    nc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      nc += int'(bus.cpu_rvalid);
      idle();
    end
    chk("s6_no_rvalid", 32'(nc), 0);
    drv(0, '0, 0, '0, 1, 0, 17'h10, '0);
    @(negedge clock);
    chk("s6_post_ready", bus.cpu_ready, 1);
    idle();
    idle();
    @(negedge clock);
    chk("s6_post_rv", bus.cpu_rvalid, 1);
    chk("s6_post_rd", bus.cpu_rdata, 16'h1234);
    repeat (3) idle();
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
